mux_rr_arbiter_sv: RTL and testbench
====================================

// Module: mux_rr_arbiter_sv
// PURPOSE
//  Round-robin arbiter that shares one 2:1 gate-level datapath mux between two
//  requesters (A, B) and drives its select line. Forwards the granted
//  requester's data downstream with a valid/ready handshake.
//  Caps each grant at MAX_BURST transfers for fairness. Sits in front of any
//  shared single-output resource in the datapath.
// PARAMETERS
//  WIDTH      1  data width of each requester and of out_data (bits)
//  MAX_BURST  4  max consecutive transfers per grant while other side waits; >=1
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst        in   1      asynchronous, active-high reset
//  req_a      in   1      requester A has data (must hold until ack_a)
//  data_a     in   WIDTH  requester A data
//  ack_a      out  1      A's word transferred this cycle
//  req_b      in   1      requester B has data (must hold until ack_b)
//  data_b     in   WIDTH  requester B data
//  ack_b      out  1      B's word transferred this cycle
//  out_valid  out  1      out_data valid for downstream
//  out_ready  in   1      downstream accepts out_data
//  out_data   out  WIDTH  mux output
//  sel        out  1      mux select; 1 = A, 0 = B
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (async, immediate):
//    - state=IDLE, sel=0, last_grant=B (so A wins first tie), burst_cnt=0.
//    - out_valid=0, ack_a=ack_b=0, busy=0.
//  - States: IDLE, GRANT_A, GRANT_B. sel is registered: GRANT_A -> 1,
//    GRANT_B -> 0, IDLE holds its last value.
//  - IDLE:
//    - Only req_a -> GRANT_A; only req_b -> GRANT_B.
//    - Both -> grant the side != last_grant. None -> stay.
//    - Grant is visible the cycle after the request is sampled
//      (1-cycle arbitration latency). No transfer happens in IDLE.
//  - GRANT_x:
//    - out_valid = req_x; out_data = mux(data_a, data_b, sel), combinational.
//    - transfer = out_valid & out_ready. ack_x = transfer, same cycle.
//      ack of the non-granted side = 0.
//    - On transfer: burst_cnt++, last_grant=x.
//    - Transfer and burst_cnt == MAX_BURST-1:
//      - Other side requesting -> switch directly to GRANT_other, burst_cnt=0.
//      - Otherwise stay in GRANT_x, burst_cnt=0.
//    - req_x low (no transfer):
//      - Other side requesting -> GRANT_other, burst_cnt=0.
//      - Otherwise -> IDLE, burst_cnt=0.
//    - out_ready low -> hold state, count and data (stall); no timeout.
//  - Switching A<->B takes 0 idle cycles; sel changes on the clock edge after
//    the deciding cycle.
//  - MAX_BURST=1: switch after every transfer when both sides request.
//  - burst_cnt width = max(1, $clog2(MAX_BURST)). The terminal compare uses
//    MAX_BURST-1, so the counter never wraps.
//  - Reset mid-burst: grant drops immediately and acks go low in the same
//    cycle. The in-flight word is not acked; the requester keeps req and
//    retries after reset.
//  - A requester dropping req without ack is a protocol violation; flag it
//    with an assertion only.
// STRUCTURE
//  - Package mux_arb_pkg: typedef enum logic [1:0] arb_state_t
//    {IDLE, GRANT_A, GRANT_B}; localparams SEL_A=1'b1, SEL_B=1'b0.
//  - Sub-module mux2_gate_sv: per-bit gate-level 2:1 mux (and/or/not),
//    instantiated WIDTH times via generate; inputs data_a, data_b, sel.
//  - Top holds the FSM, burst counter and last_grant register.
// TESTING
//  1. rst=1 mid-cycle with req_a=1 -> sel=0, out_valid=0, ack_a=0, busy=0
//     immediately.
//  2. req_a=1 only, data_a=1, out_ready=1 -> GRANT_A next cycle, sel=1,
//     out_data=1, ack_a every cycle.
//  3. req_a=req_b=1 from IDLE after reset -> A granted first. With
//     MAX_BURST=4: exactly 4 ack_a, then GRANT_B, 4 ack_b, then back to A.
//  4. GRANT_A with out_ready=0 for 5 cycles -> state, sel and burst_cnt
//     unchanged, no acks; resumes on out_ready=1.
//  5. GRANT_B, req_b drops, req_a=0 -> IDLE next cycle, sel stays 0, busy=0.
//     Then req_a=1 -> GRANT_A.
//  6. MAX_BURST=1, both requesting, out_ready=1 -> ack pattern A,B,A,B with
//     sel toggling every cycle.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
//   arb_state_t : arbiter FSM state encoding
//   SEL_A/SEL_B : mux select encoding (1 routes requester A, 0 routes B)
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/mux2_gate_sv.sv
// One-bit 2:1 multiplexer built from primitive gates.
//   data_a   in  1  routed when sel = 1
//   data_b   in  1  routed when sel = 0
//   sel      in  1  select line
//   out_data out 1  selected bit
module mux2_gate_sv (
    input  logic data_a,
    input  logic data_b,
    input  logic sel,
    output logic out_data
);

    logic sel_n;
    logic a_term;
    logic b_term;

    not u_not_sel (sel_n, sel);
    and u_and_a   (a_term, data_a, sel);
    and u_and_b   (b_term, data_b, sel_n);
    or  u_or_out  (out_data, a_term, b_term);

endmodule

// File: rtl/mux_rr_arbiter_sv.sv
// Round-robin arbiter sharing one gate-level 2:1 datapath mux between two
// requesters. The granted side's word is forwarded downstream with a
// valid/ready handshake; each grant is capped at MAX_BURST transfers while the
// other side waits.
//   clk, rst              clock, asynchronous active-high reset
//   req_a/data_a/ack_a    requester A (req held until ack)
//   req_b/data_b/ack_b    requester B (req held until ack)
//   out_valid/out_ready   downstream handshake
//   out_data              mux output
//   sel                   registered mux select (1 = A, 0 = B)
//   busy                  FSM not idle
module mux_rr_arbiter_sv
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             sel,
    output logic             busy
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    // Last transfer of a burst; comparing against MAX_BURST-1 keeps the
    // counter from ever wrapping.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_grant_q, last_grant_d;  // SEL_A / SEL_B encoding
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic grant_a;
    logic grant_b;
    logic transfer;
    logic req_own;
    logic req_other;

    assign grant_a   = (state_q == GRANT_A);
    assign grant_b   = (state_q == GRANT_B);
    assign out_valid = (grant_a & req_a) | (grant_b & req_b);
    assign transfer  = out_valid & out_ready;
    assign ack_a     = grant_a & transfer;
    assign ack_b     = grant_b & transfer;
    assign sel       = sel_q;
    assign busy      = (state_q != IDLE);

    // The granted side's request and the waiting side's request, so both
    // grant states share one set of transition rules.
    assign req_own   = grant_a ? req_a : req_b;
    assign req_other = grant_a ? req_b : req_a;

    // Datapath: one gate-level mux per bit, steered by the registered select.
    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux2_gate_sv u_mux2 (
            .data_a   (data_a[i]),
            .data_b   (data_b[i]),
            .sel      (sel_q),
            .out_data (out_data[i])
        );
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;

        unique case (state_q)
            IDLE: begin
                // On a tie, the side that did not transfer last wins.
                if (req_a && (!req_b || (last_grant_q == SEL_B))) begin
                    state_d = GRANT_A;
                    sel_d   = SEL_A;
                end else if (req_b) begin
                    state_d = GRANT_B;
                    sel_d   = SEL_B;
                end
            end

            GRANT_A, GRANT_B: begin
                if (transfer) begin
                    last_grant_d = grant_a ? SEL_A : SEL_B;
                    if (burst_cnt_q == CNT_LAST) begin
                        burst_cnt_d = '0;
                        if (req_other) begin
                            state_d = grant_a ? GRANT_B : GRANT_A;
                            sel_d   = grant_a ? SEL_B : SEL_A;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end
                end else if (!req_own) begin
                    burst_cnt_d = '0;
                    if (req_other) begin
                        state_d = grant_a ? GRANT_B : GRANT_A;
                        sel_d   = grant_a ? SEL_B : SEL_A;
                    end else begin
                        state_d = IDLE;
                    end
                end
                // Otherwise the downstream is stalling: hold everything.
            end

            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= SEL_B;
            last_grant_q <= SEL_B;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // A requester must keep req asserted until its word is acknowledged.
    a_req_a_held: assert property (@(posedge clk) disable iff (rst)
        (req_a && !ack_a) |=> req_a);
    a_req_b_held: assert property (@(posedge clk) disable iff (rst)
        (req_b && !ack_b) |=> req_b);

endmodule

// File: tb/tb_mux_rr_arbiter_sv.sv
module tb_mux_rr_arbiter_sv;

    localparam int W = 4;

    typedef struct {
        int           cyc;
        logic         side_a;
        logic [W-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_a_v     [2];
    logic         req_b_v     [2];
    logic [W-1:0] data_a_v    [2];
    logic [W-1:0] data_b_v    [2];
    logic         out_ready_v [2];
    logic         ack_a_v     [2];
    logic         ack_b_v     [2];
    logic         out_valid_v [2];
    logic [W-1:0] out_data_v  [2];
    logic         sel_v       [2];
    logic         busy_v      [2];

    int   checks   = 0;
    int   failures = 0;
    int   cyc_cnt  = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    mux_rr_arbiter_sv #(.WIDTH(W), .MAX_BURST(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .req_a(req_a_v[0]), .data_a(data_a_v[0]), .ack_a(ack_a_v[0]),
        .req_b(req_b_v[0]), .data_b(data_b_v[0]), .ack_b(ack_b_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .out_data(out_data_v[0]), .sel(sel_v[0]), .busy(busy_v[0])
    );

    mux_rr_arbiter_sv #(.WIDTH(W), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_a(req_a_v[1]), .data_a(data_a_v[1]), .ack_a(ack_a_v[1]),
        .req_b(req_b_v[1]), .data_b(data_b_v[1]), .ack_b(ack_b_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .out_data(out_data_v[1]), .sel(sel_v[1]), .busy(busy_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus on DUT d. exp: 0 = no transfer expected,
    // 1 = A's word transfers this cycle, 2 = B's word transfers this cycle.
    task automatic step(input int d, input logic ra, input logic [W-1:0] da,
                        input logic rb, input logic [W-1:0] db,
                        input logic rdy, input int exp);
        exp_t e;
        req_a_v[d]     = ra;
        data_a_v[d]    = da;
        req_b_v[d]     = rb;
        data_b_v[d]    = db;
        out_ready_v[d] = rdy;
        if (exp != 0) begin
            e.cyc    = cyc_cnt;
            e.side_a = (exp == 1);
            e.data   = (exp == 1) ? da : db;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_a_v[d] = 1'b0; req_b_v[d] = 1'b0; out_ready_v[d] = 1'b0;
            data_a_v[d] = '0;  data_b_v[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every handshake must match the next scheduled transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (out_valid_v[d] && out_ready_v[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        chk($sformatf("unexpected_xfer_dut%0d", d), 32'(1), 32'(0));
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk($sformatf("xfer_cycle_dut%0d", d), 32'(cyc_cnt), 32'(e.cyc));
                        chk($sformatf("xfer_sel_dut%0d", d), 32'(sel_v[d]), 32'(e.side_a));
                        chk($sformatf("xfer_ack_a_dut%0d", d), 32'(ack_a_v[d]), 32'(e.side_a));
                        chk($sformatf("xfer_ack_b_dut%0d", d), 32'(ack_b_v[d]), 32'(!e.side_a));
                        chk($sformatf("xfer_data_dut%0d", d), 32'(out_data_v[d]), 32'(e.data));
                    end
                end else begin
                    chk($sformatf("no_xfer_acks_dut%0d", d),
                        32'({ack_a_v[d], ack_b_v[d]}), 32'(0));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_a_v[d] = 1'b0; req_b_v[d] = 1'b0; out_ready_v[d] = 1'b0;
            data_a_v[d] = '0;  data_b_v[d] = '0;
        end
        do_reset();
        chk("reset_sel", 32'(sel_v[0]), 32'(0));
        chk("reset_valid", 32'(out_valid_v[0]), 32'(0));
        chk("reset_busy", 32'(busy_v[0]), 32'(0));

        // Reset asserted mid-cycle while A holds a stalled grant.
        step(0, 1, 4'h9, 0, 4'h0, 0, 0);
        step(0, 1, 4'h9, 0, 4'h0, 0, 0);
        chk("pre_rst_sel", 32'(sel_v[0]), 32'(1));
        chk("pre_rst_busy", 32'(busy_v[0]), 32'(1));
        chk("pre_rst_valid", 32'(out_valid_v[0]), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("midrst_sel", 32'(sel_v[0]), 32'(0));
        chk("midrst_valid", 32'(out_valid_v[0]), 32'(0));
        chk("midrst_ack_a", 32'(ack_a_v[0]), 32'(0));
        chk("midrst_busy", 32'(busy_v[0]), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Only A requests: granted next cycle, acked every cycle past the cap.
        step(0, 1, 4'h1, 0, 4'h0, 1, 0);
        chk("a_only_sel", 32'(sel_v[0]), 32'(1));
        chk("a_only_busy", 32'(busy_v[0]), 32'(1));
        chk("a_only_data", 32'(out_data_v[0]), 32'(1));
        step(0, 1, 4'h1, 0, 4'h0, 1, 1);
        step(0, 1, 4'h2, 0, 4'h0, 1, 1);
        step(0, 1, 4'h3, 0, 4'h0, 1, 1);
        step(0, 1, 4'h4, 0, 4'h0, 1, 1);
        step(0, 1, 4'h5, 0, 4'h0, 1, 1);
        step(0, 1, 4'h6, 0, 4'h0, 1, 1);

        // Both request from reset: A first, 4 each, alternating.
        do_reset();
        step(0, 1, 4'hA, 1, 4'h5, 1, 0);
        step(0, 1, 4'h1, 1, 4'hE, 1, 1);
        step(0, 1, 4'h2, 1, 4'hD, 1, 1);
        step(0, 1, 4'h3, 1, 4'hC, 1, 1);
        step(0, 1, 4'h4, 1, 4'hB, 1, 1);
        step(0, 1, 4'h5, 1, 4'h1, 1, 2);
        step(0, 1, 4'h6, 1, 4'h2, 1, 2);
        step(0, 1, 4'h7, 1, 4'h3, 1, 2);
        step(0, 1, 4'h8, 1, 4'h4, 1, 2);
        step(0, 1, 4'h9, 1, 4'h6, 1, 1);
        // Stall 5 cycles mid-burst: count, sel and state are held.
        for (int i = 0; i < 5; i++) step(0, 1, 4'hF, 1, 4'h0, 0, 0);
        chk("stall_sel", 32'(sel_v[0]), 32'(1));
        chk("stall_busy", 32'(busy_v[0]), 32'(1));
        step(0, 1, 4'hC, 1, 4'h7, 1, 1);
        step(0, 1, 4'hD, 1, 4'h8, 1, 1);
        step(0, 1, 4'hE, 1, 4'h9, 1, 1);
        step(0, 1, 4'h0, 1, 4'hA, 1, 2);

        // B drops after its ack with A idle -> IDLE; then A is granted.
        do_reset();
        step(0, 0, 4'h0, 1, 4'h3, 1, 0);
        step(0, 0, 4'h0, 1, 4'h3, 1, 2);
        step(0, 0, 4'h0, 0, 4'h0, 1, 0);
        chk("idle_busy", 32'(busy_v[0]), 32'(0));
        chk("idle_sel", 32'(sel_v[0]), 32'(0));
        chk("idle_valid", 32'(out_valid_v[0]), 32'(0));
        step(0, 1, 4'h7, 0, 4'h0, 1, 0);
        chk("regrant_sel", 32'(sel_v[0]), 32'(1));
        chk("regrant_busy", 32'(busy_v[0]), 32'(1));
        step(0, 1, 4'h7, 0, 4'h0, 1, 1);
        // A drops after its ack while B waits -> direct switch to B.
        step(0, 0, 4'h0, 1, 4'hB, 1, 0);
        chk("switch_sel", 32'(sel_v[0]), 32'(0));
        step(0, 0, 4'h0, 1, 4'hB, 1, 2);

        // MAX_BURST=1: strict alternation with both requesting.
        do_reset();
        step(1, 1, 4'h1, 1, 4'h8, 1, 0);
        step(1, 1, 4'h1, 1, 4'h8, 1, 1);
        step(1, 1, 4'h2, 1, 4'h8, 1, 2);
        step(1, 1, 4'h2, 1, 4'h9, 1, 1);
        step(1, 1, 4'h3, 1, 4'h9, 1, 2);
        step(1, 1, 4'h3, 1, 4'hA, 1, 1);

        do_reset();
        chk("dut4_all_xfers_seen", 32'(q0.size()), 32'(0));
        chk("dut1_all_xfers_seen", 32'(q1.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
